// File: rtl/seg_drive_pkg.sv
// Shared types, segment bit positions and the hex glyph table
// for the multiplexed seven-segment driver.
package seg_drive_pkg;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
    } seg_entry_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam seg_entry_t ENTRY_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}; b and d are lowercase.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational decode of one display entry to an active-high
// segment pattern (a..g in bits 0..6, dp in bit 7).
module seg_hex_decode
    import seg_drive_pkg::*;
(
    input  seg_entry_t         entry,
    output logic [SEG_W-1:0]   seg_c
);

    // A blanked digit is fully dark, decimal point included.
    always_comb begin
        seg_c = '0;
        if (!entry.blank) begin
            seg_c[SEG_G:SEG_A] = hex_to_seg(entry.value);
            seg_c[SEG_DP]      = entry.dp;
        end
    end

endmodule

// File: rtl/seg_mux_drive.sv
// Time-multiplexed seven-segment driver: shadow registers loaded over a
// valid/ready port, published to the displayed set only at frame boundaries.
module seg_mux_drive
    import seg_drive_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned DIGIT_CYCLES   = 25000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1,
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DIG_W-1:0]      wr_digit,
    input  logic [3:0]            wr_value,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    input  logic                  commit,
    output logic [SEG_W-1:0]      segment_data,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_start
);

    localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]      DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0]      IDX_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

    scan_state_t           state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [DIG_W-1:0]      idx, idx_next;
    logic                  frame_end_c;
    logic [SEG_W-1:0]      seg_next;
    logic [NUM_DIGITS-1:0] dig_next;
    logic                  fs_next;
    logic [SEG_W-1:0]      dec_seg_c;

    seg_entry_t shadow [NUM_DIGITS];
    seg_entry_t active [NUM_DIGITS];
    logic       pending;
    logic       wr_fire_c;

    assign wr_ready  = !pending;
    assign wr_fire_c = wr_valid && !pending;

    seg_hex_decode u_decode (
        .entry (active[idx]),
        .seg_c (dec_seg_c)
    );

    // Scan sequencing plus the next value of every registered output.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + 1'b1;
        idx_next    = idx;
        frame_end_c = 1'b0;
        seg_next    = SEG_OFF;
        dig_next    = DIG_OFF;
        fs_next     = (state == BLANK) && (cnt == '0) && (idx == '0);
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                end
            end
            DRIVE: begin
                seg_next = dec_seg_c ^ SEG_OFF;
                dig_next = DIG_OFF ^ (DIG_ONE << idx);
                if (cnt == DIGIT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (idx == IDX_LAST) begin
                        idx_next    = '0;
                        frame_end_c = 1'b1;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BLANK;
            cnt          <= '0;
            idx          <= '0;
            segment_data <= SEG_OFF;
            digit_en     <= DIG_OFF;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            idx          <= idx_next;
            segment_data <= seg_next;
            digit_en     <= dig_next;
            frame_start  <= fs_next;
        end
    end

    // Out-of-range digit writes match no entry and are silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= ENTRY_RESET;
                active[i] <= ENTRY_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire_c && (wr_digit == DIG_W'(i))) begin
                    shadow[i] <= '{value: wr_value, dp: wr_dp, blank: wr_blank};
                end
            end
            if (pending && frame_end_c) begin
                pending <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end else if (commit && !pending) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_drive.sv
// Bench for seg_mux_drive: two instances (4 digits active-low, 6 digits
// active-high) checked every cycle against a frame-arithmetic model.
module tb_seg_mux_drive;

    localparam int unsigned DC = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned SLOT = DC + BC;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       wv [2];
    logic [2:0] wdg [2];
    logic [3:0] wval [2];
    logic       wdp [2];
    logic       wbl [2];
    logic       cm [2];

    logic [7:0] seg0, seg1;
    logic [3:0] dig0;
    logic [5:0] dig1;
    logic       fs0, fs1, rdy0, rdy1;

    seg_mux_drive #(.NUM_DIGITS(4), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wv[0]), .wr_ready(rdy0),
        .wr_digit(wdg[0][1:0]), .wr_value(wval[0]), .wr_dp(wdp[0]), .wr_blank(wbl[0]),
        .commit(cm[0]), .segment_data(seg0), .digit_en(dig0), .frame_start(fs0));

    seg_mux_drive #(.NUM_DIGITS(6), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC),
                    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .reset(reset), .wr_valid(wv[1]), .wr_ready(rdy1),
        .wr_digit(wdg[1]), .wr_value(wval[1]), .wr_dp(wdp[1]), .wr_blank(wbl[1]),
        .commit(cm[1]), .segment_data(seg1), .digit_en(dig1), .frame_start(fs1));

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         ndig [2] = '{4, 6};
    bit         low [2]  = '{1'b1, 1'b0};
    logic [6:0] hex_tab [16];
    logic [3:0] sh_val [2][8], ac_val [2][8];
    bit         sh_dp [2][8], ac_dp [2][8], sh_bl [2][8], ac_bl [2][8];
    bit         pend [2];
    int         st [2];
    logic [7:0] exp_seg [2];
    logic [5:0] exp_dig [2];
    bit         exp_fs [2];

    int         m_frame, m_p, m_d, m_q;
    logic [7:0] m_pat;
    logic [5:0] m_en, m_mask;
    bit         m_acc;

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    // Position in the frame follows from elapsed cycles; outputs show the
    // position one cycle earlier, so expectations are formed before stepping.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            m_mask = 6'((1 << ndig[i]) - 1);
            if (reset) begin
                st[i] = 0;
                pend[i] = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    sh_val[i][j] = 4'h0; sh_dp[i][j] = 1'b0; sh_bl[i][j] = 1'b1;
                    ac_val[i][j] = 4'h0; ac_dp[i][j] = 1'b0; ac_bl[i][j] = 1'b1;
                end
                exp_seg[i] = low[i] ? 8'hFF : 8'h00;
                exp_dig[i] = low[i] ? m_mask : 6'h00;
                exp_fs[i]  = 1'b0;
            end else begin
                m_frame = ndig[i] * SLOT;
                m_p = st[i] % m_frame;
                m_d = m_p / SLOT;
                m_q = m_p % SLOT;
                m_pat = 8'h00;
                m_en = 6'h00;
                if (m_q >= BC) begin
                    m_en = 6'(1 << m_d);
                    if (!ac_bl[i][m_d]) m_pat = {ac_dp[i][m_d], hex_tab[ac_val[i][m_d]]};
                end
                exp_seg[i] = low[i] ? ~m_pat : m_pat;
                exp_dig[i] = low[i] ? (~m_en & m_mask) : m_en;
                exp_fs[i]  = (m_p == 0);
                m_acc = wv[i] && !pend[i];
                if (m_p == m_frame - 1 && pend[i]) begin
                    for (int j = 0; j < 8; j++) begin
                        ac_val[i][j] = sh_val[i][j]; ac_dp[i][j] = sh_dp[i][j]; ac_bl[i][j] = sh_bl[i][j];
                    end
                    pend[i] = 1'b0;
                end else if (cm[i] && !pend[i]) begin
                    pend[i] = 1'b1;
                end
                if (m_acc && int'(wdg[i]) < ndig[i]) begin
                    sh_val[i][wdg[i]] = wval[i];
                    sh_dp[i][wdg[i]]  = wdp[i];
                    sh_bl[i][wdg[i]]  = wbl[i];
                end
                st[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("seg0", seg0, exp_seg[0]);
            chk("dig0", 8'(dig0), 8'(exp_dig[0][3:0]));
            chk("fs0", 8'(fs0), 8'(exp_fs[0]));
            chk("rdy0", 8'(rdy0), 8'(!pend[0]));
            chk("seg1", seg1, exp_seg[1]);
            chk("dig1", 8'(dig1), 8'(exp_dig[1]));
            chk("fs1", 8'(fs1), 8'(exp_fs[1]));
            chk("rdy1", 8'(rdy1), 8'(!pend[1]));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_fs(input int i, output int n);
        logic f;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            f = (i == 0) ? fs0 : fs1;
        end while (!f && n < 200);
        if (n >= 200) chk("fs timeout", 8'(f), 8'd1);
    endtask

    task automatic wr(input int i, input int d, input logic [3:0] v, input bit dp, input bit bl);
        wv[i] = 1'b1; wdg[i] = 3'(d); wval[i] = v; wdp[i] = dp; wbl[i] = bl;
        @(negedge clk);
        wv[i] = 1'b0;
    endtask

    task automatic do_commit(input int i);
        cm[i] = 1'b1;
        @(negedge clk);
        cm[i] = 1'b0;
    endtask

    int n;

    initial begin
        for (int i = 0; i < 2; i++) begin
            wv[i] = 0; wdg[i] = 0; wval[i] = 0; wdp[i] = 0; wbl[i] = 0; cm[i] = 0;
        end
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst seg0", seg0, 8'hFF);
        chk("rst dig0", 8'(dig0), 8'h0F);
        chk("rst seg1", seg1, 8'h00);
        chk("rst dig1", 8'(dig1), 8'h00);
        chk("rst rdy0", 8'(rdy0), 8'h01);
        @(negedge clk);
        chk("first fs0", 8'(fs0), 8'h01);
        chk("k1 dig0", 8'(dig0), 8'h0F);
        @(negedge clk);
        chk("k2 dig0", 8'(dig0), 8'h0F);
        @(negedge clk);
        chk("k3 dig0", 8'(dig0), 8'h0E);
        chk("k3 seg0", seg0, 8'hFF);
        repeat (7) @(negedge clk);
        chk("k10 dig0", 8'(dig0), 8'h0E);
        @(negedge clk);
        chk("k11 dig0", 8'(dig0), 8'h0F);
        wait_fs(0, n);
        wait_fs(0, n);
        chk("fs0 period", 8'(n), 8'd40);
        wait_fs(1, n);
        wait_fs(1, n);
        chk("fs1 period", 8'(n), 8'd60);

        // Multi-digit update on the 4-digit instance
        wait_fs(0, n);
        repeat (3) @(negedge clk);
        wr(0, 0, 4'h4, 1'b1, 1'b0);
        wr(0, 1, 4'hA, 1'b0, 1'b0);
        wr(0, 2, 4'h0, 1'b0, 1'b1);
        do_commit(0);
        chk("pend rdy0", 8'(rdy0), 8'h00);
        wait_fs(0, n);
        repeat (2) @(negedge clk);
        chk("d0 seg0", seg0, 8'h19);
        chk("d0 dig0", 8'(dig0), 8'h0E);
        repeat (SLOT) @(negedge clk);
        chk("d1 seg0", seg0, 8'h88);
        chk("d1 dig0", 8'(dig0), 8'h0D);
        repeat (SLOT) @(negedge clk);
        chk("d2 seg0", seg0, 8'hFF);
        chk("d2 dig0", 8'(dig0), 8'h0B);

        // Six digits, active-high; digit 7 is out of range
        wait_fs(1, n);
        repeat (3) @(negedge clk);
        wr(1, 0, 4'h4, 1'b1, 1'b0);
        wr(1, 5, 4'h3, 1'b0, 1'b0);
        wr(1, 7, 4'h8, 1'b0, 1'b0);
        do_commit(1);
        wait_fs(1, n);
        repeat (2) @(negedge clk);
        chk("i1 d0 seg", seg1, 8'hE6);
        chk("i1 d0 dig", 8'(dig1), 8'h01);
        repeat (5 * SLOT) @(negedge clk);
        chk("i1 d5 seg", seg1, 8'h4F);
        chk("i1 d5 dig", 8'(dig1), 8'h20);

        // Write held while a commit is pending
        wait_fs(0, n);
        repeat (3) @(negedge clk);
        do_commit(0);
        chk("held rdy0 low", 8'(rdy0), 8'h00);
        wv[0] = 1'b1; wdg[0] = 3'd3; wval[0] = 4'h7; wdp[0] = 1'b0; wbl[0] = 1'b0;
        n = 0;
        while (!rdy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held rdy0 rise", 8'(rdy0), 8'h01);
        @(negedge clk);
        wv[0] = 1'b0;
        do_commit(0);
        wait_fs(0, n);
        repeat (2 + 3 * SLOT) @(negedge clk);
        chk("d3 seg0", seg0, 8'hF8);
        chk("d3 dig0", 8'(dig0), 8'h07);

        // Commit landing exactly on the boundary cycle
        wait_fs(0, n);
        wr(0, 0, 4'h9, 1'b0, 1'b0);
        repeat (37) @(negedge clk);
        do_commit(0);
        chk("bnd pend", 8'(rdy0), 8'h00);
        wait_fs(0, n);
        repeat (2) @(negedge clk);
        chk("bnd old d0", seg0, 8'h19);
        wait_fs(0, n);
        repeat (2) @(negedge clk);
        chk("bnd new d0", seg0, 8'h90);
        chk("bnd rdy0", 8'(rdy0), 8'h01);

        // Reset during digit 2 drive with a commit pending
        do_commit(0);
        n = 0;
        while (dig0 !== 4'b1011 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach d2", 8'(dig0), 8'h0B);
        #2 reset = 1'b1;
        #1;
        chk("async seg0", seg0, 8'hFF);
        chk("async dig0", 8'(dig0), 8'h0F);
        chk("async rdy0", 8'(rdy0), 8'h01);
        chk("async seg1", seg1, 8'h00);
        chk("async dig1", 8'(dig1), 8'h00);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_fs(0, n);
        do_commit(0);
        wait_fs(0, n);
        repeat (2) @(negedge clk);
        chk("post rst d0", seg0, 8'hFF);
        chk("post rst dig0", 8'(dig0), 8'h0E);

        // Random traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                wv[i]   = 1'($urandom_range(0, 1));
                wdg[i]  = 3'((i == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7));
                wval[i] = 4'($urandom_range(0, 15));
                wdp[i]  = 1'($urandom_range(0, 1));
                wbl[i]  = ($urandom_range(0, 4) == 0);
                cm[i]   = ($urandom_range(0, 19) == 0);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            wv[i] = 0; cm[i] = 0;
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
